// File: rtl/usb_ft232h_bus_arb_if.sv
// Signal bundle between the FT232H pads, the local RX/TX FIFOs and the bus arbiter.
// With USB_ARB_STATS_EN defined it also carries the transfer/switch statistics outputs.
`timescale 1ns/1ps

interface usb_ft232h_bus_arb_if;
  logic       usb_rxf_n_i;
  logic       usb_txe_n_i;
  logic [7:0] usb_data_i;
  logic [7:0] usb_data_o;
  logic       usb_data_oe_o;
  logic       usb_rd_n_o;
  logic       usb_oe_n_o;
  logic       usb_wr_n_o;
  logic       rx_full_i;
  logic       rx_wrreq_o;
  logic [7:0] rx_data_o;
  logic       tx_empty_i;
  logic [7:0] tx_q_i;
  logic       tx_rdreq_o;
  logic       busy_o;
`ifdef USB_ARB_STATS_EN
  logic [31:0] rx_count_o;
  logic [31:0] tx_count_o;
  logic [15:0] switch_count_o;
`endif

  modport master (
    input  usb_rxf_n_i, usb_txe_n_i, usb_data_i, rx_full_i, tx_empty_i, tx_q_i,
    output usb_data_o, usb_data_oe_o, usb_rd_n_o, usb_oe_n_o, usb_wr_n_o,
           rx_wrreq_o, rx_data_o, tx_rdreq_o, busy_o
`ifdef USB_ARB_STATS_EN
    , output rx_count_o, tx_count_o, switch_count_o
`endif
  );

  modport slave (
    output usb_rxf_n_i, usb_txe_n_i, usb_data_i, rx_full_i, tx_empty_i, tx_q_i,
    input  usb_data_o, usb_data_oe_o, usb_rd_n_o, usb_oe_n_o, usb_wr_n_o,
           rx_wrreq_o, rx_data_o, tx_rdreq_o, busy_o
`ifdef USB_ARB_STATS_EN
    , input rx_count_o, tx_count_o, switch_count_o
`endif
  );
endinterface

// File: rtl/usb_ft232h_bus_arb.sv
// Half-duplex scheduler for the FT232H 245 synchronous FIFO bus (usb_clk domain).
// Optional macro USB_ARB_STATS_EN adds byte counters and a forced-switch counter.
`timescale 1ns/1ps

// state       | meaning
// ST_IDLE     | bus released, choosing a direction
// ST_RX_OE    | FT232H drives the bus (oe_n low), no read strobe yet
// ST_RX_BURST | host->FPGA bytes, one per edge while rx pending
// ST_TX_BURST | FPGA drives bus, one byte per edge while tx pending
// ST_TURN     | one idle cycle for bus turnaround
module usb_ft232h_bus_arb #(
  parameter int unsigned MAX_BURST = 64,
  parameter bit          TX_FIRST  = 1'b0
) (
  input logic                   usb_clk_i,
  input logic                   nrst,
  usb_ft232h_bus_arb_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_OE,
    ST_RX_BURST,
    ST_TX_BURST,
    ST_TURN
  } state_e;

  localparam logic       DIR_RX     = 1'b0;
  localparam logic       DIR_TX     = 1'b1;
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_e     state_q, state_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       last_dir_q, last_dir_d;
  logic       dir_valid_q, dir_valid_d;

  logic       rx_pend, tx_pend;
  logic       grant_tx;
  logic       at_limit;
  logic       limit_exit;
  logic       rd_n, oe_n, wr_n, data_oe, rx_wrreq, tx_rdreq;
  logic [7:0] data_out;

  assign rx_pend  = !bus.usb_rxf_n_i && !bus.rx_full_i;
  assign tx_pend  = !bus.usb_txe_n_i && !bus.tx_empty_i;
  assign at_limit = (burst_cnt_q == BURST_LAST);
  // Until a burst has completed, last_dir carries no history, so TX_FIRST decides.
  assign grant_tx = dir_valid_q ? (last_dir_q == DIR_RX) : TX_FIRST;

  always_ff @(posedge usb_clk_i or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 8'd0;
      last_dir_q  <= DIR_RX;
      dir_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_dir_q  <= last_dir_d;
      dir_valid_q <= dir_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_dir_d  = last_dir_q;
    dir_valid_d = dir_valid_q;
    limit_exit  = 1'b0;
    rd_n        = 1'b1;
    oe_n        = 1'b1;
    wr_n        = 1'b1;
    data_oe     = 1'b0;
    rx_wrreq    = 1'b0;
    tx_rdreq    = 1'b0;
    data_out    = 8'h00;

    case (state_q)
      ST_IDLE: begin
        burst_cnt_d = 8'd0;
        if (rx_pend && tx_pend) begin
          state_d = grant_tx ? ST_TX_BURST : ST_RX_OE;
        end else if (rx_pend) begin
          state_d = ST_RX_OE;
        end else if (tx_pend) begin
          state_d = ST_TX_BURST;
        end
      end

      ST_RX_OE: begin
        oe_n    = 1'b0;
        state_d = ST_RX_BURST;
      end

      ST_RX_BURST: begin
        oe_n     = 1'b0;
        rd_n     = !rx_pend;
        rx_wrreq = rx_pend;
        if (rx_pend) begin
          // Counter holds at the limit so a long unopposed burst never wraps it.
          if (!at_limit) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
          if (at_limit && tx_pend) begin
            limit_exit  = 1'b1;
            state_d     = ST_TURN;
            last_dir_d  = DIR_RX;
            dir_valid_d = 1'b1;
          end
        end else begin
          state_d     = ST_TURN;
          last_dir_d  = DIR_RX;
          dir_valid_d = 1'b1;
        end
      end

      ST_TX_BURST: begin
        data_oe  = 1'b1;
        data_out = bus.tx_q_i;
        wr_n     = !tx_pend;
        tx_rdreq = tx_pend;
        if (tx_pend) begin
          if (!at_limit) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
          end
          if (at_limit && rx_pend) begin
            limit_exit  = 1'b1;
            state_d     = ST_TURN;
            last_dir_d  = DIR_TX;
            dir_valid_d = 1'b1;
          end
        end else begin
          state_d     = ST_TURN;
          last_dir_d  = DIR_TX;
          dir_valid_d = 1'b1;
        end
      end

      ST_TURN: begin
        burst_cnt_d = 8'd0;
        state_d     = ST_IDLE;
      end

      default: begin
        burst_cnt_d = 8'd0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  assign bus.usb_data_o    = data_out;
  assign bus.usb_data_oe_o = data_oe;
  assign bus.usb_rd_n_o    = rd_n;
  assign bus.usb_oe_n_o    = oe_n;
  assign bus.usb_wr_n_o    = wr_n;
  assign bus.rx_wrreq_o    = rx_wrreq;
  assign bus.rx_data_o     = bus.usb_data_i;
  assign bus.tx_rdreq_o    = tx_rdreq;
  assign bus.busy_o        = (state_q != ST_IDLE);

`ifdef USB_ARB_STATS_EN
  logic [31:0] rx_count_q, rx_count_d;
  logic [31:0] tx_count_q, tx_count_d;
  logic [15:0] switch_count_q, switch_count_d;

  always_ff @(posedge usb_clk_i or negedge nrst) begin
    if (!nrst) begin
      rx_count_q     <= 32'd0;
      tx_count_q     <= 32'd0;
      switch_count_q <= 16'd0;
    end else begin
      rx_count_q     <= rx_count_d;
      tx_count_q     <= tx_count_d;
      switch_count_q <= switch_count_d;
    end
  end

  always_comb begin
    rx_count_d     = rx_count_q;
    tx_count_d     = tx_count_q;
    switch_count_d = switch_count_q;
    if (rx_wrreq) begin
      rx_count_d = rx_count_q + 32'd1;
    end
    if (tx_rdreq) begin
      tx_count_d = tx_count_q + 32'd1;
    end
    if (limit_exit && (switch_count_q != 16'hFFFF)) begin
      switch_count_d = switch_count_q + 16'd1;
    end
  end

  assign bus.rx_count_o     = rx_count_q;
  assign bus.tx_count_o     = tx_count_q;
  assign bus.switch_count_o = switch_count_q;
`endif

endmodule

// File: doc/usb_ft232h_bus_arb.md
Name: usb_ft232h_bus_arb

Overview:
- Half-duplex bus scheduler for the FT232H 245 synchronous FIFO interface, in the 60 MHz usb_clk domain.
- Shares the single bidirectional data bus between RX (host->FPGA, filling the local RX FIFO) and TX (FPGA->host, draining the local TX FIFO).
- Generates rd_n/oe_n/wr_n and the data-bus output enable, inserts bus turnaround, and bounds bursts for fairness.
- Sits between the pad tristate and the dual-clock FIFOs inside usb_ft232h.

Parameters:
- MAX_BURST, 64, maximum bytes transferred in one direction before the arbiter yields if the other direction is pending; legal range 1..255.
- TX_FIRST, 0, direction granted from IDLE when both are pending (1 = TX, 0 = RX).

Ports:
- usb_clk_i  in  1  60 MHz FT232H clock; all logic on rising edge
- nrst  in  1  asynchronous active-low reset
- usb_rxf_n_i  in  1  FT232H has data for FPGA (active low)
- usb_txe_n_i  in  1  FT232H can accept data (active low)
- usb_data_i  in  8  data bus input from pad
- usb_data_o  out  8  data bus output to pad
- usb_data_oe_o  out  1  1 = FPGA drives data bus
- usb_rd_n_o  out  1  FT232H read strobe
- usb_oe_n_o  out  1  FT232H output enable
- usb_wr_n_o  out  1  FT232H write strobe
- rx_full_i  in  1  local RX FIFO full
- rx_wrreq_o  out  1  push usb_data_i into RX FIFO
- rx_data_o  out  8  data to RX FIFO (equals usb_data_i)
- tx_empty_i  in  1  local TX FIFO empty (show-ahead)
- tx_q_i  in  8  TX FIFO head byte
- tx_rdreq_o  out  1  pop TX FIFO
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (nrst low, async): state IDLE, burst_cnt 0, last_dir RX.
  - Reset output values: rd_n/oe_n/wr_n = 1, usb_data_oe_o = 0, rx_wrreq_o = 0, tx_rdreq_o = 0.
- Pending terms: rx_pend = !usb_rxf_n_i & !rx_full_i; tx_pend = !usb_txe_n_i & !tx_empty_i.
- States:
  - IDLE -> RX_OE on rx_pend; -> TX_BURST on tx_pend.
    - Both pending: TX_FIRST selects the direction out of reset.
    - Thereafter the direction opposite last_dir wins.
  - RX_OE:
    - usb_oe_n_o = 0 for exactly one cycle, no strobe.
    - Next state RX_BURST.
  - RX_BURST:
    - usb_oe_n_o = 0; usb_rd_n_o = !rx_pend (combinational).
    - rx_wrreq_o = rx_pend; each such edge transfers one byte and increments burst_cnt.
    - Exit to TURN when rx_pend falls, or when burst_cnt reaches MAX_BURST-1 on a transfer edge while tx_pend is high.
    - Exit sets last_dir = RX.
  - TX_BURST:
    - usb_data_oe_o = 1; usb_data_o = tx_q_i.
    - usb_wr_n_o = !tx_pend; tx_rdreq_o = tx_pend.
    - Byte accepted on the same edge; burst_cnt increments.
    - Exit to TURN on !tx_pend, or on the MAX_BURST limit with rx_pend high.
    - Exit sets last_dir = TX.
  - TURN:
    - One cycle; all strobes high, oe_n high, data_oe 0.
    - Next state IDLE; burst_cnt cleared.
- Bus contention:
  - usb_data_oe_o and !usb_oe_n_o are never both 1 in any cycle.
  - Minimum gap between them is one full cycle: via TURN, plus the RX_OE cycle on entry to RX.
- Burst limit ignored if the other direction is not pending; the burst continues.
- rx_full_i rising mid-burst: rd_n rises the same cycle, no byte lost, and the state exits to TURN.
- usb_txe_n_i rising mid-burst: wr_n rises and tx_rdreq_o drops the same cycle, so the head byte is retained. Exit to TURN.
- Latency:
  - IDLE to first RX byte: 2 cycles.
  - IDLE to first TX byte: 1 cycle.
- burst_cnt width 8; it never wraps because it saturates at MAX_BURST-1 by exit.

Optional Feature:
- Macro: USB_ARB_STATS_EN.
- Defined:
  - Adds outputs rx_count_o[31:0] and tx_count_o[31:0], counting transferred bytes.
  - Counters wrap modulo 2^32 and reset to 0 on nrst.
  - Also adds switch_count_o[15:0], incremented on each limit-forced exit; it saturates at 0xFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-TX_BURST (nrst low for 3 ns between edges) -> all strobes 1 and data_oe 0 immediately; IDLE after release.
- rxf_n low, rx FIFO not full, 10 bytes 0x00..0x09 -> oe_n low 1 cycle before rd_n; rx_wrreq_o pulses 10 times; data matches; TURN; IDLE.
- TX FIFO holds 256 bytes, txe_n low, rxf_n high -> continuous 256-byte burst; wr_n low 256 cycles; no forced switch.
- Both pending continuously, MAX_BURST=64 -> bursts alternate RX/TX, each exactly 64 bytes; at each transition data_oe and !oe_n are separated by at least 1 cycle.
- txe_n pulses high for 2 cycles at TX byte 5 -> byte 5 is not popped; after resume byte 5 is the next byte written; no duplicates or gaps.
- rx_full_i asserts after byte 3 -> rd_n high the same cycle; exactly 3 pushes; state returns to IDLE.
